dmem_arbiter: RTL and testbench

//  Shares the single-port Data_Memory between two requesters: port 0 = pipeline MEM stage,

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_rr_pick.sv | 21 ++
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_AUX = 1;

    // Width of the access-latency down-counter, which holds values 0 .. lat-1.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes to the
// port that was not granted last.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic       gnt_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        if (req_i[PORT_CPU] && req_i[PORT_AUX]) begin
            gnt_o = ~last_gnt_i;
        end else begin
            gnt_o = req_i[PORT_AUX];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the pipeline MEM stage
// (port 0) and an auxiliary master (port 1). Optional bounds check: DMEM_ARB_BOUNDS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned DEPTH   = 256
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [1:0]    req_i,
    input  logic [1:0]    we_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic [1:0]    ack_o,
    output logic [DW-1:0] rdata_o,
    output logic          err_o,
    output logic          stall0_o,
    output logic          busy_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_we_o,
    output logic          mem_re_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int unsigned   CW      = cnt_width(MEM_LAT);
    localparam logic [CW-1:0] CntLoad = CW'(MEM_LAT - 1);
    localparam int unsigned   XW      = ((AW > 32) ? AW : 32) + 1;

`ifdef DMEM_ARB_BOUNDS_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    arb_state_e    state_q;
    logic          last_gnt_q;
    logic          gnt_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    ack_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic          mem_we_q;
    logic          mem_re_q;

    logic          gnt;
    logic          gnt_valid;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;
    logic          we_sel;
    logic          oob;

    dmem_rr_pick u_rr_pick (
        .req_i      (req_i),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (gnt),
        .valid_o    (gnt_valid)
    );

    always_comb begin
        addr_sel  = gnt ? addr1_i : addr0_i;
        wdata_sel = gnt ? wdata1_i : wdata0_i;
        we_sel    = we_i[gnt];
        // Zero-extend both sides so DEPTH larger than the address range never wraps.
        oob       = BoundsEn && (XW'(addr_sel) >= XW'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        last_gnt_q <= gnt;
                        gnt_q      <= gnt;
                        we_q       <= we_sel;
                        addr_q     <= addr_sel;
                        wdata_q    <= wdata_sel;
                        if (oob) begin
                            // Out-of-range access is answered at once without touching memory.
                            ack_q[gnt] <= 1'b1;
                            err_q      <= 1'b1;
                        end else begin
                            state_q  <= BUSY;
                            cnt_q    <= CntLoad;
                            mem_re_q <= ~we_sel;
                            mem_we_q <= we_sel && (CntLoad == '0);
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q    <= cnt_q - CW'(1);
                        // The single write strobe lands in the final BUSY cycle.
                        mem_we_q <= we_q && (cnt_q == CW'(1));
                    end else begin
                        if (!we_q) begin
                            rdata_q <= mem_rdata_i;
                        end
                        ack_q[gnt_q] <= 1'b1;
                        state_q      <= IDLE;
                        mem_re_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ack_o       = ack_q;
        rdata_o     = rdata_q;
        err_o       = err_q;
        busy_o      = (state_q == BUSY);
        stall0_o    = req_i[PORT_CPU] & ~ack_q[PORT_CPU];
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_we_o    = mem_we_q;
        mem_re_o    = mem_re_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter against a transaction-schedule reference model.
module tb_dmem_arbiter;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned MEM_LAT = 3;
    localparam int unsigned DEPTH   = 256;

`ifdef DMEM_ARB_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic [1:0]    req_i;
    logic [1:0]    we_i;
    logic [AW-1:0] addr0_i;
    logic [AW-1:0] addr1_i;
    logic [DW-1:0] wdata0_i;
    logic [DW-1:0] wdata1_i;
    logic [1:0]    ack_o;
    logic [DW-1:0] rdata_o;
    logic          err_o;
    logic          stall0_o;
    logic          busy_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_we_o;
    logic          mem_re_o;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .MEM_LAT (MEM_LAT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr0_i     (addr0_i),
        .addr1_i     (addr1_i),
        .wdata0_i    (wdata0_i),
        .wdata1_i    (wdata1_i),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .stall0_o    (stall0_o),
        .busy_o      (busy_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_we_o    (mem_we_o),
        .mem_re_o    (mem_re_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // Data memory: combinational read, write on the rising edge.
    logic [DW-1:0] tb_mem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (mem_we_o) tb_mem[mem_addr_o[7:0]] <= mem_wdata_o;
    end
    assign mem_rdata_i = tb_mem[mem_addr_o[7:0]];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one scheduled transaction, described by the windows (cycles between
    // rising edges) in which it is busy and in which its ack appears.
    logic [DW-1:0] shadow [DEPTH] = '{default: '0};
    longint        w;
    bit            g_active;
    bit            g_port;
    bit            g_we;
    bit            g_err;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    longint        g_first;
    longint        g_ack;
    bit            last_port;
    logic [DW-1:0] rdata_hold;
    logic [1:0]    cur_ack;
    int            mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s window=%0d got=%0h exp=%0h", tag, w, got, exp);
        end
    endtask

    task automatic model_reset();
        g_active   = 1'b0;
        last_port  = 1'b1;
        rdata_hold = '0;
        cur_ack    = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, ack_o, 0);
        check({tag, "_rdata"}, rdata_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_mwe"}, mem_we_o, 0);
        check({tag, "_mre"}, mem_re_o, 0);
        check({tag, "_maddr"}, mem_addr_o, 0);
        check({tag, "_mwdata"}, mem_wdata_o, 0);
    endtask

    task automatic m_check();
        bit         busy_e;
        logic [1:0] ack_e;
        if (g_active && w == g_ack && !g_err) begin
            if (g_we) shadow[g_addr[7:0]] = g_wdata;
            else      rdata_hold = shadow[g_addr[7:0]];
        end
        busy_e = g_active && !g_err && (w >= g_first) && (w < g_ack);
        ack_e  = '0;
        if (g_active && w == g_ack) ack_e[g_port] = 1'b1;
        check("ack", ack_o, ack_e);
        check("err", err_o, g_active && w == g_ack && g_err);
        check("busy", busy_o, busy_e);
        check("mem_re", mem_re_o, busy_e && !g_we);
        check("mem_we", mem_we_o, busy_e && g_we && (w == g_ack - 1));
        check("rdata", rdata_o, rdata_hold);
        if (busy_e) check("mem_addr", mem_addr_o, g_addr);
        if (busy_e && g_we) check("mem_wdata", mem_wdata_o, g_wdata);
        cur_ack = ack_e;
    endtask

    task automatic new_payload(input int p);
        logic [AW-1:0] a;
        a = AW'($urandom_range(15, 0));
        if (BOUNDS && $urandom_range(7, 0) == 0) a = AW'(DEPTH + $urandom_range(100, 0));
        we_i[p] = 1'($urandom_range(1, 0));
        if (p == 0) begin
            addr0_i  = a;
            wdata0_i = $urandom;
        end else begin
            addr1_i  = a;
            wdata1_i = $urandom;
        end
    endtask

    // mode 0: random traffic with occasional withdrawals; 1: both ports saturate; 2: quiet.
    task automatic drive_agents();
        for (int p = 0; p < 2; p++) begin
            if (mode == 2) begin
                req_i[p] = 1'b0;
            end else if (req_i[p] && cur_ack[p]) begin
                if (mode == 1 || $urandom_range(1, 0) == 1) new_payload(p);
                else req_i[p] = 1'b0;
            end else if (!req_i[p]) begin
                if (mode == 1 || $urandom_range(2, 0) == 0) begin
                    new_payload(p);
                    req_i[p] = 1'b1;
                end
            end else if (mode == 0 && $urandom_range(31, 0) == 0) begin
                req_i[p] = 1'b0;
            end
        end
    endtask

    task automatic m_arb();
        if ((!g_active || w >= g_ack) && req_i != 2'b00) begin
            if (req_i == 2'b11) g_port = ~last_port;
            else                g_port = req_i[1];
            last_port = g_port;
            g_active  = 1'b1;
            g_we      = we_i[g_port];
            g_addr    = g_port ? addr1_i : addr0_i;
            g_wdata   = g_port ? wdata1_i : wdata0_i;
            g_err     = BOUNDS && (g_addr >= AW'(DEPTH));
            g_first   = w + 1;
            g_ack     = g_err ? w + 1 : w + 1 + MEM_LAT;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        w++;
        m_check();
        drive_agents();
        m_arb();
        #1;
        check("stall0", stall0_o, req_i[0] && !cur_ack[0]);
    endtask

    initial begin
        rst_i    = 1'b0;
        req_i    = '0;
        we_i     = '0;
        addr0_i  = '0;
        addr1_i  = '0;
        wdata0_i = '0;
        wdata1_i = '0;
        w        = 0;
        mode     = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_i = 1'b1;

        mode = 0;
        repeat (1500) cycle();
        mode = 1;
        repeat (500) cycle();
        mode = 2;
        repeat (MEM_LAT + 3) cycle();

        // Reset during the first BUSY cycle of a write: the strobe must never be issued.
        @(negedge clk);
        w++;
        m_check();
        req_i    = 2'b10;
        we_i     = 2'b10;
        addr1_i  = AW'(9);
        wdata1_i = ~shadow[9];
        m_arb();
        @(negedge clk);
        w++;
        m_check();
        rst_i = 1'b0;
        req_i = '0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        check("mem9_kept", tb_mem[9], shadow[9]);
        rst_i = 1'b1;

        mode = 1;
        repeat (300) cycle();
        mode = 0;
        repeat (500) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
